uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- Parametrised successor to the single-byte UART receiver.
- Generalises frame format to configurable data width, parity mode and stop-bit count.
- Adds input synchronisation, start-glitch rejection, parity/framing/overrun error detection and an internal first-word-fall-through (FWFT) receive FIFO.
- Sits between the board RX pin and the SHA-256 message loader, which drains bytes via a read-enable handshake.

Parameters:
- CLKS_PER_BIT, 868: clocks per bit (100 MHz / 115200); must be ≥ 4.
- DATA_BITS, 8: data bits per frame, legal 5..9, sent LSB first.
- PARITY_MODE, 0: 0 none, 1 even, 2 odd.
- STOP_BITS, 1: legal 1 or 2.
- FIFO_DEPTH, 16: FIFO entries, power of 2, ≥ 2.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- Rx_Serial_in  in  1  asynchronous serial line, idle high.
- Rd_En_in  in  1  pop FIFO head; ignored when empty.
- Err_Clr_in  in  1  clears all sticky error flags.
- Rx_Byte_out  out  DATA_BITS  FIFO head data; valid when Rx_Empty_out = 0.
- Rx_Empty_out  out  1  FIFO empty.
- Rx_Full_out  out  1  FIFO full.
- Rx_Count_out  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- Parity_Err_out  out  1  sticky: parity mismatch seen.
- Frame_Err_out  out  1  sticky: a stop bit sampled low.
- Overrun_Err_out  out  1  sticky: good frame dropped because FIFO was full.

Behaviour:
- Reset values:
  - Rx_Byte_out = 0, Rx_Empty_out = 1, Rx_Full_out = 0, Rx_Count_out = 0.
  - All error flags = 0.
  - FIFO pointers = 0.
  - FSM = WAIT_IDLE.
  - Synchroniser flops = 1.
- Reset mid-frame aborts the frame and discards all FIFO contents.
- Synchronisation: Rx_Serial_in passes through a 2-flop synchroniser; every decision below uses the synchronised value (rx_s).
- Sampling: bit counter clk_cnt runs 0..CLKS_PER_BIT-1; each bit is sampled when clk_cnt = CLKS_PER_BIT-1, i.e. mid-bit after the start alignment.
- FSM states:
  - WAIT_IDLE: stay until rx_s = 1, then go to IDLE. Prevents mid-frame capture after reset or a framing error.
  - IDLE: on rx_s = 0 go to START with clk_cnt = 0.
  - START: at clk_cnt = (CLKS_PER_BIT-1)/2, recheck rx_s. If 0, go to DATA with clk_cnt = 0. If 1, it is a glitch: return to IDLE with no flag.
  - DATA: shift in DATA_BITS samples LSB first. Then go to PARITY if PARITY_MODE ≠ 0, else STOP.
  - PARITY: sample one bit; compute even/odd parity over the data bits; latch the mismatch internally.
  - STOP: sample STOP_BITS bits; any 0 sets a framing failure.
  - COMMIT: one cycle, then return.
- COMMIT outcome:
  - Framing failure: no push, set Frame_Err_out, go to WAIT_IDLE.
  - Parity mismatch: no push, set Parity_Err_out, go to IDLE.
  - Good frame with FIFO not full: push, go to IDLE.
  - Good frame with FIFO full and Rd_En_in = 0: drop, set Overrun_Err_out.
  - Good frame with FIFO full and Rd_En_in = 1: push and pop in the same cycle; no overrun; count unchanged.
- FIFO latency: the pushed byte is visible on Rx_Byte_out, with Rx_Empty_out = 0, on the cycle after COMMIT.
- FIFO read: Rd_En_in with non-empty FIFO pops on that edge; the next head appears the following cycle. Rd_En_in when empty has no effect.
- Pointers: wrap modulo FIFO_DEPTH. Rx_Full_out = 1 exactly when Rx_Count_out = FIFO_DEPTH.
- Error flags: set and clear on the same cycle (Err_Clr_in) resolves to set.
- Frame length: with CLKS_PER_BIT = N, a 10-bit 8N1 frame commits about 9.5·N + 4 clocks after the falling edge on Rx_Serial_in.

Test Plan:
- T1 basic: CLKS_PER_BIT = 16, 8N1; send 0x61, 0x62, 0x63 back-to-back; pop after each → reads 0x61, 0x62, 0x63; no error flags; Rx_Empty_out = 1 at end.
- T2 FIFO fill/overrun: FIFO_DEPTH = 4, no reads; send 0x10..0x14 → Rx_Full_out = 1 and Rx_Count_out = 4 after the 4th byte; 5th byte dropped and Overrun_Err_out = 1. Then pop 4 → 0x10..0x13 in order, then Rx_Empty_out = 1.
- T3 parity: PARITY_MODE = 1 (even); send 0x61 with parity bit 1 → pushed; send 0x61 with parity bit 0 → not pushed, Parity_Err_out = 1. Pulse Err_Clr_in → flag returns to 0.
- T4 framing/glitch:
  - Drive a low pulse of 3 clocks → no frame started, no flags.
  - Send 0x55 with stop bit 0, hold line low for 2 bit times, then release → Frame_Err_out = 1, nothing pushed; the next valid 0xA5 is received correctly.
- T5 generic widths: DATA_BITS = 7, PARITY_MODE = 2 (odd), STOP_BITS = 2; send 0x7F with correct framing → Rx_Byte_out = 7'h7F. With the second stop bit 0 → Frame_Err_out = 1.
- T6 reset and simultaneous events:
  - Assert RST_N = 0 midway through a DATA bit with 2 bytes queued → outputs return to reset values immediately; the partial frame is not received.
  - With the FIFO full, pulse Rd_En_in exactly on the COMMIT cycle → count stays FIFO_DEPTH and no overrun.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with configurable frame format, error flags and FWFT receive FIFO
// Oversampled receiver: mid-bit sampling, start-glitch rejection, sticky parity/framing/overrun flags.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic                            Rx_Serial_in,
  input  logic                            Rd_En_in,
  input  logic                            Err_Clr_in,
  output logic [DATA_BITS-1:0]            Rx_Byte_out,
  output logic                            Rx_Empty_out,
  output logic                            Rx_Full_out,
  output logic [$clog2(FIFO_DEPTH):0]     Rx_Count_out,
  output logic                            Parity_Err_out,
  output logic                            Frame_Err_out,
  output logic                            Overrun_Err_out
);

  localparam int LP_CW = $clog2(CLKS_PER_BIT);
  localparam int LP_AW = $clog2(FIFO_DEPTH);
  localparam int LP_NW = LP_AW + 1;
  localparam logic [LP_CW-1:0] LP_BIT_LAST  = LP_CW'(CLKS_PER_BIT - 1);
  localparam logic [LP_CW-1:0] LP_BIT_HALF  = LP_CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [3:0]       LP_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       LP_STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [LP_NW-1:0] LP_FULL      = LP_NW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_WAIT_IDLE, S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_COMMIT
  } state_t;

  logic                 r_sync1, r_sync2;
  state_t               r_state, w_state_nxt;
  logic [LP_CW-1:0]     r_clk_cnt, w_cnt_nxt;
  logic [3:0]           r_bit_idx, w_idx_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_par_bad, w_par_bad_nxt;
  logic                 r_frm_bad, w_frm_bad_nxt;
  logic                 w_commit_ok, w_set_par, w_set_frm;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [LP_AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [LP_NW-1:0]     r_count;
  logic                 r_par_err, r_frm_err, r_ovr_err;

  logic w_rx_s, w_tick, w_par_exp, w_empty, w_full, w_push, w_pop, w_set_ovr;

  assign w_rx_s    = r_sync2;
  assign w_tick    = (r_clk_cnt == LP_BIT_LAST);
  assign w_par_exp = (PARITY_MODE == 2) ? ~^r_shift : ^r_shift;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= Rx_Serial_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_WAIT_IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_par_bad <= 1'b0;
      r_frm_bad <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clk_cnt <= w_cnt_nxt;
      r_bit_idx <= w_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_par_bad <= w_par_bad_nxt;
      r_frm_bad <= w_frm_bad_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_clk_cnt;
    w_idx_nxt     = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_par_bad_nxt = r_par_bad;
    w_frm_bad_nxt = r_frm_bad;
    w_commit_ok   = 1'b0;
    w_set_par     = 1'b0;
    w_set_frm     = 1'b0;
    case (r_state)
      S_WAIT_IDLE: if (w_rx_s) w_state_nxt = S_IDLE;
      S_IDLE: begin
        w_cnt_nxt     = '0;
        w_idx_nxt     = '0;
        w_par_bad_nxt = 1'b0;
        w_frm_bad_nxt = 1'b0;
        if (!w_rx_s) w_state_nxt = S_START;
      end
      S_START: begin
        // A start bit must still be low at its midpoint, otherwise it was noise.
        if (r_clk_cnt == LP_BIT_HALF) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
          if (r_bit_idx == LP_DATA_LAST) begin
            w_idx_nxt   = '0;
            w_state_nxt = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            w_idx_nxt = r_bit_idx + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_cnt_nxt     = '0;
          w_par_bad_nxt = (w_rx_s != w_par_exp);
          w_state_nxt   = S_STOP;
        end else begin
          w_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          w_cnt_nxt = '0;
          if (!w_rx_s) w_frm_bad_nxt = 1'b1;
          if (r_bit_idx == LP_STOP_LAST) w_state_nxt = S_COMMIT;
          else                           w_idx_nxt   = r_bit_idx + 1'b1;
        end else begin
          w_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      S_COMMIT: begin
        // Framing failure takes priority: the line may be stuck low, so wait for idle.
        if (r_frm_bad) begin
          w_set_frm   = 1'b1;
          w_state_nxt = S_WAIT_IDLE;
        end else if (r_par_bad) begin
          w_set_par   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_commit_ok = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_WAIT_IDLE;
    endcase
  end

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == LP_FULL);
  assign w_pop     = Rd_En_in && !w_empty;
  assign w_push    = w_commit_ok && (!w_full || Rd_En_in);
  assign w_set_ovr = w_commit_ok && w_full && !Rd_En_in;

  // When full, a simultaneous pop frees the head slot which wr_ptr also addresses.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
      r_ovr_err <= 1'b0;
    end else begin
      r_par_err <= w_set_par | (r_par_err & ~Err_Clr_in);
      r_frm_err <= w_set_frm | (r_frm_err & ~Err_Clr_in);
      r_ovr_err <= w_set_ovr | (r_ovr_err & ~Err_Clr_in);
    end
  end

  assign Rx_Byte_out     = w_empty ? '0 : r_mem[r_rd_ptr];
  assign Rx_Empty_out    = w_empty;
  assign Rx_Full_out     = w_full;
  assign Rx_Count_out    = r_count;
  assign Parity_Err_out  = r_par_err;
  assign Frame_Err_out   = r_frm_err;
  assign Overrun_Err_out = r_ovr_err;

endmodule
